// File: rtl/div32_ctrl_if.sv
// Request/response handshake bundle for div32_ctrl.
// master = requester/consumer side, slave = controller side.
interface div32_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_dividend;
    logic [WIDTH-1:0] req_divisor;
    logic             req_signed;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_quotient;
    logic [WIDTH-1:0] rsp_remainder;
    logic             rsp_dbz;
    logic             rsp_err;

    modport master (
        output req_valid, req_dividend, req_divisor, req_signed, rsp_ready,
        input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz, rsp_err
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor, req_signed, rsp_ready,
        output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz, rsp_err
    );
endinterface

// File: rtl/div32_ctrl.sv
// div32_ctrl: request sequencer around the 32-cycle restoring divider.
// Converts operands to magnitudes, starts the divider, waits for a fresh
// finish, sign-corrects the result and holds it on the response port.
// Divide-by-zero and signed overflow are answered locally in one cycle.
// Optional: define DIV32_CTRL_FASTPATH_EN to also answer |divisor|==1 and
// |dividend|<|divisor| locally without starting the divider.
module div32_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40
) (
    input  logic             clk,
    input  logic             rst,
    div32_ctrl_if.slave      bus,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    output logic             div_start,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    input  logic             div_finish
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
`ifdef DIV32_CTRL_FASTPATH_EN
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
`endif

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_FIX   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] div_a_q, div_a_d;
    logic [WIDTH-1:0] div_b_q, div_b_d;
    logic [WIDTH-1:0] raw_quo_q, raw_quo_d;
    logic [WIDTH-1:0] raw_rem_q, raw_rem_d;
    logic [WIDTH-1:0] rsp_quo_q, rsp_quo_d;
    logic [WIDTH-1:0] rsp_rem_q, rsp_rem_d;
    logic             rsp_dbz_q, rsp_dbz_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             seen_low_q, seen_low_d;
    logic [TW-1:0]    timer_q, timer_d;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    // Operand magnitudes; only signed operands with the top bit set are negated.
    always_comb begin
        sign_a = bus.req_signed & bus.req_dividend[WIDTH-1];
        sign_b = bus.req_signed & bus.req_divisor[WIDTH-1];
        mag_a  = sign_a ? -bus.req_dividend : bus.req_dividend;
        mag_b  = sign_b ? -bus.req_divisor  : bus.req_divisor;
    end

    // Next-state and datapath decisions for the sequencer.
    always_comb begin
        state_d     = state_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        raw_quo_d   = raw_quo_q;
        raw_rem_d   = raw_rem_q;
        rsp_quo_d   = rsp_quo_q;
        rsp_rem_d   = rsp_rem_q;
        rsp_dbz_d   = rsp_dbz_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = rsp_valid_q;
        seen_low_d  = seen_low_q;
        timer_d     = timer_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    neg_quo_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    div_a_d   = mag_a;
                    div_b_d   = mag_b;
                    rsp_dbz_d = 1'b0;
                    rsp_err_d = 1'b0;
                    if (bus.req_divisor == '0) begin
                        rsp_quo_d   = ALL_ONES;
                        rsp_rem_d   = bus.req_dividend;
                        rsp_dbz_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else if (bus.req_signed && bus.req_dividend == MIN_VAL &&
                                 bus.req_divisor == ALL_ONES) begin
                        rsp_quo_d   = MIN_VAL;
                        rsp_rem_d   = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = S_DONE;
`ifdef DIV32_CTRL_FASTPATH_EN
                    end else if (mag_b == ONE_VAL) begin
                        rsp_quo_d   = (sign_a ^ sign_b) ? -mag_a : mag_a;
                        rsp_rem_d   = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else if (mag_a < mag_b) begin
                        rsp_quo_d   = '0;
                        rsp_rem_d   = bus.req_dividend;
                        rsp_valid_d = 1'b1;
                        state_d     = S_DONE;
`endif
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                seen_low_d = 1'b0;
                timer_d    = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (!div_finish) begin
                    seen_low_d = 1'b1;
                end
                // A finish level still high from an earlier operation is not
                // trusted until the divider has been seen to drop it.
                if (div_finish && seen_low_q) begin
                    raw_quo_d = div_quotient;
                    raw_rem_d = div_remainder;
                    state_d   = S_FIX;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    rsp_quo_d   = '0;
                    rsp_rem_d   = '0;
                    rsp_dbz_d   = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_FIX: begin
                rsp_quo_d   = neg_quo_q ? -raw_quo_q : raw_quo_q;
                rsp_rem_d   = neg_rem_q ? -raw_rem_q : raw_rem_q;
                rsp_dbz_d   = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset discards any in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            raw_quo_q   <= '0;
            raw_rem_q   <= '0;
            rsp_quo_q   <= '0;
            rsp_rem_q   <= '0;
            rsp_dbz_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            seen_low_q  <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            raw_quo_q   <= raw_quo_d;
            raw_rem_q   <= raw_rem_d;
            rsp_quo_q   <= rsp_quo_d;
            rsp_rem_q   <= rsp_rem_d;
            rsp_dbz_q   <= rsp_dbz_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            seen_low_q  <= seen_low_d;
            timer_q     <= timer_d;
        end
    end

    assign bus.req_ready     = (state_q == S_IDLE);
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_quotient  = rsp_quo_q;
    assign bus.rsp_remainder = rsp_rem_q;
    assign bus.rsp_dbz       = rsp_dbz_q;
    assign bus.rsp_err       = rsp_err_q;
    assign div_dividend      = div_a_q;
    assign div_divisor       = div_b_q;
    assign div_start         = (state_q == S_START);
endmodule

// File: tb/tb_div32_ctrl.sv
// Bench for div32_ctrl: a behavioural divider (33-cycle finish after start),
// a directed vector table, hand sequences for the multi-cycle corners, and
// randomized requests checked against plain-arithmetic expectations.
module tb_div32_ctrl;
    localparam int W        = 32;
    localparam int TMO      = 40;
    localparam int LAT_DIV  = 36;          // 3 + 33 divider cycles
    localparam int LAT_TMO  = TMO + 3;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] div_dividend, div_divisor, div_quotient, div_remainder;
    logic        div_start, div_finish;

    div32_ctrl_if #(.WIDTH(W)) bus ();

    div32_ctrl #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_start    (div_start),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .div_finish   (div_finish)
    );

    always #5 clk = ~clk;

    // Behavioural divider: finish drops on start, rises 32 edges later.
    logic dm_stuck = 1'b0;
    int   dm_cnt   = 0;
    int   start_cnt = 0;
    initial begin
        div_finish    = 1'b1;
        div_quotient  = 32'hDEAD_BEEF;
        div_remainder = 32'hCAFE_F00D;
    end
    always @(posedge clk) begin
        if (div_start) start_cnt++;
        if (dm_stuck) begin
            div_finish <= 1'b1;
        end else if (div_start) begin
            div_finish    <= 1'b0;
            dm_cnt        <= 32;
            div_quotient  <= (div_divisor == 0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
            div_remainder <= (div_divisor == 0) ? div_dividend  : div_dividend % div_divisor;
        end else if (dm_cnt > 0) begin
            dm_cnt <= dm_cnt - 1;
            if (dm_cnt == 1) div_finish <= 1'b1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero.
    function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output logic dbz);
        longint sa, sb;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a; dbz = 1'b1;
        end else begin
            sa = s ? longint'($signed(a)) : longint'({32'd0, a});
            sb = s ? longint'($signed(b)) : longint'({32'd0, b});
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            dbz = 1'b0;
        end
    endfunction

    function automatic bit is_bypass(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        if (sa < 0) sa = -sa;
        if (sb < 0) sb = -sb;
        if (b == 0) return 1'b1;
        if (s && a == MINV && b == 32'hFFFF_FFFF) return 1'b1;
`ifdef DIV32_CTRL_FASTPATH_EN
        if (sb == 1 || sa < sb) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Issue one request and return the response; hold = cycles rsp_ready stays low.
    task automatic run_txn(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold,
                           output logic [31:0] q, output logic [31:0] r,
                           output logic dbz, output logic err, output int lat);
        int guard = 0;
        while (!bus.req_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        chk("req_ready_before_issue", {31'd0, bus.req_ready}, 32'd1);
        start_cnt = 0;
        bus.req_valid = 1'b1; bus.req_signed = s;
        bus.req_dividend = a; bus.req_divisor = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        chk("rsp_valid_arrives", {31'd0, bus.rsp_valid}, 32'd1);
        q = bus.rsp_quotient; r = bus.rsp_remainder;
        dbz = bus.rsp_dbz; err = bus.rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("hold_quotient", bus.rsp_quotient, q);
            chk("hold_remainder", bus.rsp_remainder, r);
            chk("hold_req_ready_low", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drops", {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    task automatic check_txn(input string tag, input bit s, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                             input logic edbz, input int hold);
        logic [31:0] q, r;
        logic dbz, err;
        int lat, elat;
        bit byp;
        byp  = is_bypass(s, a, b);
        elat = byp ? 1 : LAT_DIV;
        run_txn(s, a, b, hold, q, r, dbz, err, lat);
        $display("%s s=%0d a=%h b=%h -> q=%h r=%h dbz=%0d err=%0d lat=%0d starts=%0d",
                 tag, s, a, b, q, r, dbz, err, lat, start_cnt);
        chk({tag, " quotient"}, q, eq);
        chk({tag, " remainder"}, r, er);
        chk({tag, " dbz"}, {31'd0, dbz}, {31'd0, edbz});
        chk({tag, " err"}, {31'd0, err}, 32'd0);
        chk({tag, " latency"}, lat, elat);
        chk({tag, " start_pulses"}, start_cnt, byp ? 0 : 1);
    endtask

    typedef struct {
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] q, r, eq, er;
        logic dbz, err, edbz;
        int lat, seen;
        bit s;
        logic [31:0] a, b;

        vecs[0] = '{1'b0, 32'd100,       32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1] = '{1'b1, 32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
        vecs[2] = '{1'b1, 32'd100,       32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0};
        vecs[3] = '{1'b0, 32'h1234_5678, 32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
        vecs[4] = '{1'b1, 32'h1234_5678, 32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
        vecs[5] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        vecs[6] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
        vecs[7] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
        vecs[8] = '{1'b0, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[9] = '{1'b0, 32'd3,         32'd5,          32'd0,          32'd3,          1'b0};

        bus.req_valid = 1'b0; bus.req_signed = 1'b0;
        bus.req_dividend = '0; bus.req_divisor = '0; bus.rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset div_start", {31'd0, div_start}, 32'd0);
        chk("reset rsp_quotient", bus.rsp_quotient, 32'd0);
        chk("reset rsp_remainder", bus.rsp_remainder, 32'd0);
        chk("reset dbz_err", {30'd0, bus.rsp_dbz, bus.rsp_err}, 32'd0);
        chk("reset div_dividend", div_dividend, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 10; i++)
            check_txn($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
                      vecs[i].q, vecs[i].r, vecs[i].dbz, 0);

        // Consumer stalls 10 cycles: response must hold, no new request accepted
        check_txn("hold10", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 10);

        // rsp_ready already high when rsp_valid rises: transfer completes that edge
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_signed = 1'b0;
        bus.req_dividend = 32'd55; bus.req_divisor = 32'd0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("sameedge valid_up", {31'd0, bus.rsp_valid}, 32'd1);
        chk("sameedge dbz", {31'd0, bus.rsp_dbz}, 32'd1);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("sameedge valid_down", {31'd0, bus.rsp_valid}, 32'd0);
        chk("sameedge req_ready", {31'd0, bus.req_ready}, 32'd1);
        $display("sameedge s=0 a=00000037 b=00000000 dbz transfer");

        // Divider finish stuck high: stale level ignored, timeout error
        dm_stuck = 1'b1;
        @(posedge clk); #1;
        run_txn(1'b0, 32'd100, 32'd7, 0, q, r, dbz, err, lat);
        $display("timeout s=0 a=00000064 b=00000007 -> q=%h r=%h dbz=%0d err=%0d lat=%0d",
                 q, r, dbz, err, lat);
`ifndef DIV32_CTRL_FASTPATH_EN
        chk("timeout err", {31'd0, err}, 32'd1);
        chk("timeout quotient", q, 32'd0);
        chk("timeout remainder", r, 32'd0);
        chk("timeout latency", lat, LAT_TMO);
`else
        chk("timeout err", {31'd0, err}, 32'd1);
        chk("timeout quotient", q, 32'd0);
        chk("timeout remainder", r, 32'd0);
        chk("timeout latency", lat, LAT_TMO);
`endif
        dm_stuck = 1'b0;
        @(posedge clk); #1;

        // Reset asserted while waiting on the divider
        bus.req_valid = 1'b1; bus.req_signed = 1'b0;
        bus.req_dividend = 32'd1000; bus.req_divisor = 32'd3;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("midreset req_ready", {31'd0, bus.req_ready}, 32'd1);
        seen = 0;
        repeat (45) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen++;
        end
        chk("midreset no_response", seen, 0);
        $display("midreset s=0 a=000003e8 b=00000003 aborted, responses_after=%0d", seen);

        // Randomized requests against the reference
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin s = 1'b1; a = MINV; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: b = -($urandom_range(1, 15));
                4: begin a = $urandom_range(0, 20); b = $urandom_range(1, 40); end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            ref_div(s, a, b, eq, er, edbz);
            check_txn($sformatf("rnd%0d", i), s, a, b, eq, er, edbz, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
